// File: rtl/alu_op_driver.sv
// -----------------------------------------------------------------------------
// alu_op_driver
//
// Initiator-side front end for the single-cycle ALU. One request
// (req_op, req_a, req_b) is accepted over a valid/ready handshake and driven
// onto the ALU ports. After SETTLE_CYCLES rising edges the ALU outputs are
// captured and returned over a valid/ready response channel.
//
// Optional feature macro: ALU_DRV_CHECK_EN
//   defined   : a golden model checks the captured values at capture time.
//               chk_mismatch pulses and chk_err sets (sticky until rst).
//   undefined : no golden logic. chk_mismatch and chk_err are tied to 0.
//
// Parameters
//   SETTLE_CYCLES : rising edges from ALU port update to capture (1..15)
//   CNT_W         : width of the completed-operation counter
//
// Ports
//   clk, rst                        : clock and async active-high reset
//   req_valid/req_ready             : request handshake
//   req_op/req_a/req_b              : ALU control encoding and operands
//   alu_a/alu_b/alu_ctrl            : registered operands to the ALU
//   alu_result/alu_carry/alu_zero   : ALU outputs
//   rsp_valid/rsp_ready             : response handshake
//   rsp_result/rsp_carry/rsp_zero   : captured ALU outputs
//   op_count                        : completed responses, wraps
//   chk_mismatch/chk_err            : golden-check pulse and sticky flag
// -----------------------------------------------------------------------------
module alu_op_driver #(
    parameter int SETTLE_CYCLES = 1,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [6:0]       req_op,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    output logic [6:0]       alu_ctrl,
    input  logic [31:0]      alu_result,
    input  logic             alu_carry,
    input  logic             alu_zero,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_result,
    output logic             rsp_carry,
    output logic             rsp_zero,
    output logic [CNT_W-1:0] op_count,
    output logic             chk_mismatch,
    output logic             chk_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] settle_cnt;

    logic accept;
    logic capture;
    logic release_rsp;

    assign accept      = req_valid && req_ready;
    // Capture on the edge where the settle counter steps from 1 to 0.
    assign capture     = (state == ST_WAIT) && (settle_cnt == 4'd1);
    assign release_rsp = (state == ST_RESP) && rsp_valid && rsp_ready;

    // ---------------------------------------------------------------- state register
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------------------------------------------------------- next state
    // NOTE: state_nxt gets a default before the case so no path leaves it
    // unassigned; a missing default here would infer a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (accept)      state_nxt = ST_WAIT;
            ST_WAIT: if (capture)     state_nxt = ST_RESP;
            ST_RESP: if (release_rsp) state_nxt = ST_IDLE;
            default:                  state_nxt = ST_IDLE;
        endcase
    end

    // ---------------------------------------------------------------- outputs
    always_comb begin
        req_ready = (state == ST_IDLE) && !rst;
    end

    // ---------------------------------------------------------------- datapath
    // alu_* hold the last issued operation between requests; only reset clears them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a      <= '0;
            alu_b      <= '0;
            alu_ctrl   <= '0;
            settle_cnt <= '0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_carry  <= 1'b0;
            rsp_zero   <= 1'b0;
            op_count   <= '0;
        end else begin
            if (accept) begin
                alu_a      <= req_a;
                alu_b      <= req_b;
                alu_ctrl   <= req_op;
                settle_cnt <= SETTLE_LOAD;
            end else if (state == ST_WAIT) begin
                settle_cnt <= settle_cnt - 4'd1;
            end

            if (capture) begin
                rsp_result <= alu_result;
                rsp_carry  <= alu_carry;
                rsp_zero   <= alu_zero;
                rsp_valid  <= 1'b1;
            end else if (release_rsp) begin
                rsp_valid  <= 1'b0;
                op_count   <= op_count + CNT_W'(1);
            end
        end
    end

`ifdef ALU_DRV_CHECK_EN
    localparam logic [6:0] OP_ADD  = 7'b1000000;
    localparam logic [6:0] OP_AND  = 7'b0000001;
    localparam logic [6:0] OP_XOR  = 7'b0000010;
    localparam logic [6:0] OP_COMP = 7'b1001000;
    localparam logic [6:0] OP_SLL  = 7'b0010011;
    localparam logic [6:0] OP_SRL  = 7'b0000011;
    localparam logic [6:0] OP_SRA  = 7'b0100011;

    logic [31:0] gold_result;
    logic        gold_carry;
    logic        gold_listed;
    logic        mismatch;

    // Golden values are derived from the registered operands, which are
    // exactly what the ALU sees during the settle window.
    always_comb begin
        gold_result = '0;
        gold_carry  = 1'b0;
        gold_listed = 1'b1;
        case (alu_ctrl)
            OP_ADD:  {gold_carry, gold_result} = {1'b0, alu_a} + {1'b0, alu_b};
            OP_AND:  gold_result = alu_a & alu_b;
            OP_XOR:  gold_result = alu_a ^ alu_b;
            OP_COMP: gold_result = 32'd0 - alu_b;
            OP_SLL:  gold_result = alu_a << alu_b[4:0];
            OP_SRL:  gold_result = alu_a >> alu_b[4:0];
            OP_SRA:  gold_result = 32'($signed(alu_a) >>> alu_b[4:0]);
            default: gold_listed = 1'b0;
        endcase
    end

    // Carry is only meaningful for ADD; unlisted opcodes are never flagged.
    assign mismatch = gold_listed &&
                      ((alu_result != gold_result) ||
                       (alu_zero != (gold_result == 32'd0)) ||
                       ((alu_ctrl == OP_ADD) && (alu_carry != gold_carry)));

    // Registered at the capture edge so the pulse lines up with the first
    // cycle of rsp_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chk_mismatch <= 1'b0;
            chk_err      <= 1'b0;
        end else begin
            chk_mismatch <= capture && mismatch;
            if (capture && mismatch) begin
                chk_err <= 1'b1;
            end
        end
    end
`else
    assign chk_mismatch = 1'b0;
    assign chk_err      = 1'b0;
`endif

endmodule

// File: tb/tb_alu_op_driver.sv
// -----------------------------------------------------------------------------
// tb_alu_op_driver
//
// Drives alu_op_driver through directed and random operations. A behavioural
// ALU stands in for the real one (with an optional fault to force a wrong
// result), and expected responses, latency, counter and check flags are
// computed from the operation rules directly.
// -----------------------------------------------------------------------------
module tb_alu_op_driver;

    localparam int S  = 4;
    localparam int CW = 16;

`ifdef ALU_DRV_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    localparam logic [6:0] OP_ADD  = 7'b1000000;
    localparam logic [6:0] OP_AND  = 7'b0000001;
    localparam logic [6:0] OP_XOR  = 7'b0000010;
    localparam logic [6:0] OP_COMP = 7'b1001000;
    localparam logic [6:0] OP_SLL  = 7'b0010011;
    localparam logic [6:0] OP_SRL  = 7'b0000011;
    localparam logic [6:0] OP_SRA  = 7'b0100011;
    localparam logic [6:0] OP_UNL  = 7'b1111111;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [6:0]    req_op;
    logic [31:0]   req_a;
    logic [31:0]   req_b;
    logic [31:0]   alu_a;
    logic [31:0]   alu_b;
    logic [6:0]    alu_ctrl;
    logic [31:0]   alu_result;
    logic          alu_carry;
    logic          alu_zero;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [31:0]   rsp_result;
    logic          rsp_carry;
    logic          rsp_zero;
    logic [CW-1:0] op_count;
    logic          chk_mismatch;
    logic          chk_err;

    always #5 clk = ~clk;

    alu_op_driver #(.SETTLE_CYCLES(S), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .alu_carry(alu_carry), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_carry(rsp_carry), .rsp_zero(rsp_zero),
        .op_count(op_count),
        .chk_mismatch(chk_mismatch), .chk_err(chk_err)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic [31:0] result;
        logic        carry;
        logic        zero;
    } alu_out_t;

    function automatic bit is_listed(input logic [6:0] op);
        return op inside {OP_ADD, OP_AND, OP_XOR, OP_COMP, OP_SLL, OP_SRL, OP_SRA};
    endfunction

    // ALU behaviour from the operation definitions. Unlisted opcodes get an
    // arbitrary but deterministic behaviour so their transport is still checked.
    function automatic alu_out_t ref_alu(input logic [6:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
        alu_out_t        r;
        longint unsigned sum;
        int              sh;
        r   = '0;
        sh  = int'(b[4:0]);
        sum = longint'(a) + longint'(b);
        case (op)
            OP_ADD: begin
                r.result = sum[31:0];
                r.carry  = sum[32];
            end
            OP_AND:  r.result = a & b;
            OP_XOR:  r.result = a ^ b;
            OP_COMP: r.result = 32'(-longint'(b));
            OP_SLL:  r.result = a << sh;
            OP_SRL:  r.result = a >> sh;
            OP_SRA:  r.result = 32'($signed(a) >>> sh);
            default: begin
                r.result = a - b + 32'd7;
                r.carry  = a[0];
            end
        endcase
        r.zero = (r.result == 32'd0);
        return r;
    endfunction

    // Stand-in ALU, optionally faulted to return result+1.
    logic     inject;
    alu_out_t alu_o;
    always_comb begin
        alu_o = ref_alu(alu_ctrl, alu_a, alu_b);
        if (inject) begin
            alu_o.result = alu_o.result + 32'd1;
            alu_o.zero   = (alu_o.result == 32'd0);
        end
    end
    assign alu_result = alu_o.result;
    assign alu_carry  = alu_o.carry;
    assign alu_zero   = alu_o.zero;

    int unsigned exp_count = 0;
    bit          exp_err   = 1'b0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issue one operation and hold off the response for `hold` cycles.
    task automatic do_op(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int hold);
        alu_out_t e;
        bit       mm;
        int       waited;
        e = ref_alu(op, a, b);
        if (inject) begin
            e.result = e.result + 32'd1;
            e.zero   = (e.result == 32'd0);
        end
        mm = CHK && inject && is_listed(op);

        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_valid = 1'b1;
        rsp_ready = (hold == 0);
        waited    = 0;
        while (!req_ready && waited < 20) begin
            tick;
            waited++;
        end
        if (!req_ready) begin
            check("accept_timeout", 64'(req_ready), 64'd1);
            req_valid = 1'b0;
            return;
        end
        tick;                                   // acceptance edge T0
        req_valid = 1'b0;
        check("alu_a", 64'(alu_a), 64'(a));
        check("alu_b", 64'(alu_b), 64'(b));
        check("alu_ctrl", 64'(alu_ctrl), 64'(op));

        for (int k = 0; k < S; k++) begin
            check("req_ready_busy", 64'(req_ready), 64'd0);
            check("rsp_valid_early", 64'(rsp_valid), 64'd0);
            tick;
        end
        // Now at T0+S: capture has happened.
        check("rsp_valid", 64'(rsp_valid), 64'd1);
        check("rsp_result", 64'(rsp_result), 64'(e.result));
        check("rsp_carry", 64'(rsp_carry), 64'(e.carry));
        check("rsp_zero", 64'(rsp_zero), 64'(e.zero));
        check("chk_mismatch", 64'(chk_mismatch), 64'(mm));
        if (mm) exp_err = 1'b1;
        check("chk_err", 64'(chk_err), 64'(exp_err));

        if (hold > 0) begin
            // A competing request is presented while the response is stalled.
            req_valid = 1'b1;
            req_a     = ~a;
            for (int h = 0; h < hold; h++) begin
                tick;
                check("bp_rsp_valid", 64'(rsp_valid), 64'd1);
                check("bp_rsp_result", 64'(rsp_result), 64'(e.result));
                check("bp_req_ready", 64'(req_ready), 64'd0);
                check("bp_alu_a", 64'(alu_a), 64'(a));
                check("bp_mismatch_pulse", 64'(chk_mismatch), 64'd0);
            end
            rsp_ready = 1'b1;
        end

        tick;                                   // handshake edge
        req_valid = 1'b0;
        exp_count++;
        check("rsp_valid_clr", 64'(rsp_valid), 64'd0);
        check("op_count", 64'(op_count), 64'(exp_count[CW-1:0]));
        check("mismatch_pulse_end", 64'(chk_mismatch), 64'd0);
        check("req_ready_idle", 64'(req_ready), 64'd1);
        check("alu_a_hold", 64'(alu_a), 64'(a));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_alu_a"}, 64'(alu_a), 64'd0);
        check({tag, "_alu_b"}, 64'(alu_b), 64'd0);
        check({tag, "_alu_ctrl"}, 64'(alu_ctrl), 64'd0);
        check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        check({tag, "_rsp_result"}, 64'(rsp_result), 64'd0);
        check({tag, "_rsp_carry"}, 64'(rsp_carry), 64'd0);
        check({tag, "_rsp_zero"}, 64'(rsp_zero), 64'd0);
        check({tag, "_op_count"}, 64'(op_count), 64'd0);
        check({tag, "_chk_mismatch"}, 64'(chk_mismatch), 64'd0);
        check({tag, "_chk_err"}, 64'(chk_err), 64'd0);
        check({tag, "_req_ready"}, 64'(req_ready), 64'd0);
    endtask

    logic [6:0] op_tab [8] = '{OP_ADD, OP_AND, OP_XOR, OP_COMP, OP_SLL, OP_SRL, OP_SRA, OP_UNL};

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        inject    = 1'b0;
        tick;
        tick;
        check_all_zero("reset");
        rst = 1'b0;
        #1;
        check("req_ready_after_reset", 64'(req_ready), 64'd1);

        // Directed operations.
        do_op(OP_ADD, 32'd10, 32'd101, 0);
        do_op(OP_ADD, 32'd10000, -32'sd10000, 0);
        do_op(OP_SLL, 32'd1432, 32'd6, 0);
        do_op(OP_SRA, -32'sd1324, 32'd9, 0);
        do_op(OP_XOR, 32'hDEAD_BEEF, 32'h1234_5678, 5);
        do_op(OP_COMP, 32'd3, 32'd0, 0);
        do_op(OP_SRL, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        do_op(OP_ADD, 32'hFFFF_FFFF, 32'd1, 0);

        // Faulted ALU: listed opcode flags, unlisted does not; chk_err stays set.
        inject = 1'b1;
        do_op(OP_ADD, 32'd10, 32'd101, 0);
        do_op(OP_UNL, 32'd55, 32'd3, 0);
        inject = 1'b0;
        do_op(OP_ADD, 32'd10, 32'd101, 0);
        do_op(OP_AND, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1);

        // Reset two cycles into WAIT aborts the operation.
        req_op    = OP_ADD;
        req_a     = 32'd7;
        req_b     = 32'd8;
        req_valid = 1'b1;
        tick;
        req_valid = 1'b0;
        tick;
        tick;
        rst = 1'b1;
        #1;
        check_all_zero("mid_wait_reset");
        tick;
        rst       = 1'b0;
        exp_count = 0;
        exp_err   = 1'b0;
        for (int k = 0; k < S + 2; k++) begin
            tick;
            check("no_rsp_after_abort", 64'(rsp_valid), 64'd0);
        end
        check("op_count_after_abort", 64'(op_count), 64'd0);
        do_op(OP_ADD, 32'd10, 32'd101, 0);

        // Random operations.
        for (int n = 0; n < 40; n++) begin
            do_op(op_tab[$urandom_range(0, 7)], $urandom, $urandom, int'($urandom_range(0, 2)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
